// File: rtl/rtc_pkg.sv
// Shared BCD types, limits and validation used by the timekeeper and calendar set paths.
package rtc_pkg;

    typedef logic [7:0] bcd_t;

    localparam bcd_t BCD_59 = 8'h59;
    localparam bcd_t BCD_23 = 8'h23;

    // Both nibbles must be decimal digits and the whole byte must not exceed max.
    function automatic logic bcd_valid(input bcd_t b, input bcd_t max);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that rolls from MAX_BCD to 00; wrap flags the rolling increment.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter bcd_t MAX_BCD = BCD_59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    input  bcd_t       load_val,
    output bcd_t       value,
    output logic       wrap
);

    bcd_t r_value;

    assign value = r_value;
    assign wrap  = inc && (r_value == MAX_BCD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 8'h00;
        end else if (load) begin
            r_value <= load_val;
        end else if (inc) begin
            if (r_value == MAX_BCD) begin
                r_value <= 8'h00;
            end else if (r_value[3:0] == 4'd9) begin
                r_value <= {r_value[7:4] + 4'd1, 4'd0};
            end else begin
                r_value <= {r_value[7:4], r_value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// 1 Hz prescaler driving a chained BCD hh:mm:ss clock with a validated load port.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PRESCALE_W = 26
) (
    input  logic        d_clk,
    input  logic        rst_n,
    input  logic        run_en,
    input  logic        set_time,
    input  logic [7:0]  set_hour,
    input  logic [7:0]  set_min,
    input  logic [7:0]  set_sec,
    output logic [7:0]  real_sec,
    output logic [7:0]  real_min,
    output logic [7:0]  real_hour,
    output logic [23:0] full_time,
    output logic        sec_tick,
    output logic        day_tick,
    output logic        set_err
);

    localparam logic [PRESCALE_W-1:0] LP_LAST = PRESCALE_W'(CLK_HZ - 1);

    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_sec_tick;
    logic                  r_day_tick;
    logic                  r_set_err;

    logic w_set_ok;
    logic w_load;
    logic w_presc_wrap;
    logic w_sec_inc;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hour_wrap;

    assign w_set_ok     = bcd_valid(set_hour, BCD_23) && bcd_valid(set_min, BCD_59)
                          && bcd_valid(set_sec, BCD_59);
    assign w_load       = set_time && w_set_ok;
    assign w_presc_wrap = run_en && (r_presc == LP_LAST);
    // A valid load on the wrap edge discards that second's increment.
    assign w_sec_inc    = w_presc_wrap && !w_load;

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            if (w_load || w_presc_wrap) begin
                r_presc <= '0;
            end else if (run_en) begin
                r_presc <= r_presc + 1'b1;
            end
            r_sec_tick <= w_sec_inc;
            r_day_tick <= w_hour_wrap;
            r_set_err  <= set_time && !w_set_ok;
        end
    end

    bcd_mod_counter #(.MAX_BCD(BCD_59)) u_sec (
        .clk      (d_clk),
        .rst_n    (rst_n),
        .inc      (w_sec_inc),
        .load     (w_load),
        .load_val (set_sec),
        .value    (real_sec),
        .wrap     (w_sec_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_59)) u_min (
        .clk      (d_clk),
        .rst_n    (rst_n),
        .inc      (w_sec_wrap),
        .load     (w_load),
        .load_val (set_min),
        .value    (real_min),
        .wrap     (w_min_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_23)) u_hour (
        .clk      (d_clk),
        .rst_n    (rst_n),
        .inc      (w_min_wrap),
        .load     (w_load),
        .load_val (set_hour),
        .value    (real_hour),
        .wrap     (w_hour_wrap)
    );

    assign full_time = {real_hour, real_min, real_sec};
    assign sec_tick  = r_sec_tick;
    assign day_tick  = r_day_tick;
    assign set_err   = r_set_err;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with a 4-cycle second.
module tb_rtc_timekeeper;

    logic        d_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic        set_time = 1'b0;
    logic [7:0]  set_hour = 8'h00;
    logic [7:0]  set_min = 8'h00;
    logic [7:0]  set_sec = 8'h00;
    logic [7:0]  real_sec;
    logic [7:0]  real_min;
    logic [7:0]  real_hour;
    logic [23:0] full_time;
    logic        sec_tick;
    logic        day_tick;
    logic        set_err;

    int n_checks = 0;
    int n_errors = 0;

    rtc_timekeeper #(.CLK_HZ(4), .PRESCALE_W(3)) dut (
        .d_clk     (d_clk),
        .rst_n     (rst_n),
        .run_en    (run_en),
        .set_time  (set_time),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .real_sec  (real_sec),
        .real_min  (real_min),
        .real_hour (real_hour),
        .full_time (full_time),
        .sec_tick  (sec_tick),
        .day_tick  (day_tick),
        .set_err   (set_err)
    );

    always #5 d_clk = ~d_clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge d_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hour = h;
        set_min  = m;
        set_sec  = s;
        set_time = 1'b1;
        tick();
        set_time = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic st, input logic dt, input logic se);
        check({tag, "_sec_tick"}, {23'd0, sec_tick}, {23'd0, st});
        check({tag, "_day_tick"}, {23'd0, day_tick}, {23'd0, dt});
        check({tag, "_set_err"},  {23'd0, set_err},  {23'd0, se});
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_time", full_time, 24'h000000);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // Free run from reset: one second per 4 cycles
        rst_n  = 1'b1;
        run_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("run_sec_tick", {23'd0, sec_tick}, {23'd0, (k % 4 == 0)});
            check("run_sec", {16'd0, real_sec}, {16'd0, 8'(k / 4)});
        end
        check("run_full", full_time, 24'h000003);

        // Midnight rollover
        load(8'h23, 8'h59, 8'h58);
        check("ld_235958", full_time, 24'h235958);
        check_flags("ld_235958", 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("mid_sec_tick", {23'd0, sec_tick}, {23'd0, (k == 4 || k == 8)});
            check("mid_day_tick", {23'd0, day_tick}, {23'd0, (k == 8)});
            if (k == 4) check("mid_235959", full_time, 24'h235959);
        end
        check("mid_000000", full_time, 24'h000000);
        tick();
        check_flags("mid_after", 1'b0, 1'b0, 1'b0);

        // Hour digit carries 09->10 and 19->20 (prescaler is at 1 here; load clears it)
        load(8'h09, 8'h59, 8'h59);
        repeat (4) tick();
        check("h10_time", full_time, 24'h100000);
        check_flags("h10", 1'b1, 1'b0, 1'b0);
        load(8'h19, 8'h59, 8'h59);
        repeat (4) tick();
        check("h20_time", full_time, 24'h200000);
        check_flags("h20", 1'b1, 1'b0, 1'b0);

        // Rejected loads leave time and prescaler alone
        tick();
        load(8'h24, 8'h00, 8'h00);
        check("bad_hour_time", full_time, 24'h200000);
        check_flags("bad_hour", 1'b0, 1'b0, 1'b1);
        tick();
        check_flags("bad_hour_next", 1'b0, 1'b0, 1'b0);
        tick();
        check("bad_hour_tick_time", full_time, 24'h200001);
        check_flags("bad_hour_tick", 1'b1, 1'b0, 1'b0);
        tick();
        load(8'h12, 8'h5A, 8'h00);
        check("bad_min_time", full_time, 24'h200001);
        check_flags("bad_min", 1'b0, 1'b0, 1'b1);
        tick();
        check_flags("bad_min_next", 1'b0, 1'b0, 1'b0);
        tick();
        check("bad_min_tick_time", full_time, 24'h200002);
        check_flags("bad_min_tick", 1'b1, 1'b0, 1'b0);

        // Load on the exact wrap edge wins
        repeat (3) tick();
        load(8'h12, 8'h00, 8'h00);
        check("wrapld_time", full_time, 24'h120000);
        check_flags("wrapld", 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("wrapld_hold", full_time, 24'h120000);
        check_flags("wrapld_hold", 1'b0, 1'b0, 1'b0);
        tick();
        check("wrapld_next", full_time, 24'h120001);
        check_flags("wrapld_next", 1'b1, 1'b0, 1'b0);

        // run_en low freezes prescaler and time
        repeat (2) tick();
        run_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("frz_tick", {23'd0, sec_tick}, 24'd0);
        end
        check("frz_time", full_time, 24'h120001);
        run_en = 1'b1;
        tick();
        check("unfrz_pre", full_time, 24'h120001);
        tick();
        check("unfrz_time", full_time, 24'h120002);
        check_flags("unfrz", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-second
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_time", full_time, 24'h000000);
        check_flags("arst", 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("post_rst_time", full_time, 24'h000000);
            check_flags("post_rst", 1'b0, 1'b0, 1'b0);
        end
        tick();
        check("post_rst_sec", full_time, 24'h000001);
        check_flags("post_rst_sec", 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
